// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB and sets the immediate extender mode.
// Latency: one cycle per state; lw 5, R/I-ALU/sw 4, beq/bne/j 3 cycles, plus memory wait states.
// Backpressure: stalls in FETCH/MEM until mem_ready; halts after TIMEOUT_CYCLES+1 unready cycles (0 = wait forever).
module mc_control_fsm #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] instr_op,
    input  logic [5:0] instr_funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] ext_sel,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [2:0] state,
    output logic       err_illegal,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Instruction class latched in DECODE; I-ALU ops are split so EXEC needs no opcode.
    typedef enum logic [3:0] {
        C_RTYPE = 4'd0,
        C_LW    = 4'd1,
        C_SW    = 4'd2,
        C_BEQ   = 4'd3,
        C_BNE   = 4'd4,
        C_ADDI  = 4'd5,
        C_ADDIU = 4'd6,
        C_SLTI  = 4'd7,
        C_ANDI  = 4'd8,
        C_ORI   = 4'd9,
        C_LUI   = 4'd10,
        C_J     = 4'd11,
        C_ILL   = 4'd12
    } cls_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    cls_t            r_cls;
    cls_t            w_dec_cls;
    logic [1:0]      r_ext_sel;
    logic [1:0]      w_dec_ext;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_waiting;
    logic            w_timeout;
    logic            w_set_ill;
    logic            r_err_ill;
    logic            r_err_to;
    logic            w_unused_funct;

    // The funct field is consumed by the ALU decoder when alu_op = 111, not here.
    assign w_unused_funct = ^instr_funct;

    assign state       = r_state;
    assign err_illegal = r_err_ill;
    assign err_timeout = r_err_to;

    // Opcode to instruction class and extender mode.
    always_comb begin
        w_dec_cls = C_ILL;
        w_dec_ext = EXT_SIGN;
        case (instr_op)
            6'h00: w_dec_cls = C_RTYPE;
            6'h23: w_dec_cls = C_LW;
            6'h2B: w_dec_cls = C_SW;
            6'h04: w_dec_cls = C_BEQ;
            6'h05: w_dec_cls = C_BNE;
            6'h08: w_dec_cls = C_ADDI;
            6'h09: w_dec_cls = C_ADDIU;
            6'h0A: w_dec_cls = C_SLTI;
            6'h0C: begin w_dec_cls = C_ANDI; w_dec_ext = EXT_ZERO;  end
            6'h0D: begin w_dec_cls = C_ORI;  w_dec_ext = EXT_ZERO;  end
            6'h0F: begin w_dec_cls = C_LUI;  w_dec_ext = EXT_UPPER; end
            6'h02: w_dec_cls = C_J;
            default: w_dec_cls = C_ILL;
        endcase
    end

    // Wait-state counter: counts unready FETCH/MEM cycles; a ready on the limit cycle wins.
    always_comb begin
        w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
        w_timeout = (TIMEOUT_CYCLES != 0) && w_waiting && (r_cnt == CW'(TIMEOUT_CYCLES));
        w_cnt_nxt = (w_waiting && !w_timeout && (TIMEOUT_CYCLES != 0)) ? r_cnt + CW'(1) : '0;
    end

    // State register; reset aborts any instruction immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Decoded class, held extender mode, wait counter and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cls     <= C_RTYPE;
            r_ext_sel <= EXT_SIGN;
            r_cnt     <= '0;
            r_err_ill <= 1'b0;
            r_err_to  <= 1'b0;
        end else begin
            if (r_state == S_DECODE) begin
                r_cls     <= w_dec_cls;
                r_ext_sel <= w_dec_ext;
            end
            r_cnt <= w_cnt_nxt;
            if (w_set_ill) begin
                r_err_ill <= 1'b1;
            end
            if (w_timeout) begin
                r_err_to <= 1'b1;
            end
        end
    end

    // Next state and datapath controls; everything defaults to 0 so RST/HALT drive nothing.
    always_comb begin
        w_state_nxt = r_state;
        w_set_ill   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        i_or_d      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = ALU_ADD;
        ext_sel     = r_ext_sel;
        reg_we      = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        case (r_state)
            S_RST: begin
                ext_sel     = EXT_SIGN;
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we       = 1'b1;
                    pc_we       = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_op      = ALU_ADD;
                    w_state_nxt = S_DECODE;
                end else if (w_timeout) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                ext_sel = w_dec_ext;
                if (w_dec_cls == C_ILL) begin
                    w_set_ill   = 1'b1;
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_WB;
                case (r_cls)
                    C_RTYPE: begin alu_src_b = 2'b00; alu_op = ALU_FUNCT; end
                    C_ADDI, C_ADDIU, C_LUI: begin alu_src_b = 2'b10; alu_op = ALU_ADD; end
                    C_SLTI:  begin alu_src_b = 2'b10; alu_op = ALU_SLT; end
                    C_ANDI:  begin alu_src_b = 2'b10; alu_op = ALU_AND; end
                    C_ORI:   begin alu_src_b = 2'b10; alu_op = ALU_OR;  end
                    C_LW, C_SW: begin
                        alu_src_b   = 2'b10;
                        alu_op      = ALU_ADD;
                        w_state_nxt = S_MEM;
                    end
                    C_BEQ, C_BNE: begin
                        alu_src_b   = 2'b00;
                        alu_op      = ALU_SUB;
                        pc_src      = 2'b01;
                        pc_we       = (r_cls == C_BEQ) ? alu_zero : !alu_zero;
                        w_state_nxt = S_FETCH;
                    end
                    C_J: begin
                        pc_we       = 1'b1;
                        pc_src      = 2'b10;
                        w_state_nxt = S_FETCH;
                    end
                    default: w_state_nxt = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = (r_cls == C_SW);
                if (mem_ready) begin
                    w_state_nxt = (r_cls == C_SW) ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_WB: begin
                reg_we      = 1'b1;
                mem_to_reg  = (r_cls == C_LW);
                reg_dst     = (r_cls == C_RTYPE);
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                ext_sel     = EXT_SIGN;
                w_state_nxt = S_HALT;
            end
            default: begin
                ext_sel     = EXT_SIGN;
                w_state_nxt = S_HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-cycle stimulus with expected controls queued on a scoreboard.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, before the next rising edge.
// Runs with TIMEOUT_CYCLES = 4 so the timeout and ready-at-limit cases stay short.
module tb_mc_control_fsm;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LUI = 6'h0F;
    localparam logic [5:0] OP_SLT = 6'h0A;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BAD = 6'h3F;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] ext_sel;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       err_il;
        logic       err_to;
    } ctl_t;

    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic       zero;
        logic [5:0] op;
    } stim_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] instr_op = OP_LW;
    logic [5:0] instr_funct = 6'h20;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, i_or_d, ir_we, pc_we;
    logic [1:0] pc_src, alu_src_b, ext_sel;
    logic [2:0] alu_op, state;
    logic       reg_we, reg_dst, mem_to_reg, err_illegal, err_timeout;

    int    checks = 0;
    int    errors = 0;
    ctl_t  sb[$];
    stim_t stim_q[$];

    mc_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .instr_op(instr_op), .instr_funct(instr_funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .i_or_d(i_or_d), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_sel(ext_sel), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
        .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic ctl_t sample();
        ctl_t c;
        c = {state, mem_req, mem_we, i_or_d, ir_we, pc_we, pc_src, alu_src_b, alu_op,
             ext_sel, reg_we, reg_dst, mem_to_reg, err_illegal, err_timeout};
        return c;
    endfunction

    function automatic stim_t s(input logic rst, input logic rdy, input logic zero, input logic [5:0] op);
        stim_t x;
        x.rst = rst; x.rdy = rdy; x.zero = zero; x.op = op;
        return x;
    endfunction

    // Expected control words, written directly from the state table.
    function automatic ctl_t c_rst();
        ctl_t c = '0;
        return c;
    endfunction

    function automatic ctl_t c_halt(input logic il, input logic to);
        ctl_t c = '0;
        c.st = 3'd6; c.err_il = il; c.err_to = to;
        return c;
    endfunction

    function automatic ctl_t c_fetch(input logic rdy, input logic [1:0] ext);
        ctl_t c = '0;
        c.st = 3'd1; c.mem_req = 1'b1; c.ext_sel = ext;
        if (rdy) begin
            c.ir_we = 1'b1; c.pc_we = 1'b1; c.alu_src_b = 2'b01;
        end
        return c;
    endfunction

    function automatic ctl_t c_decode(input logic [1:0] ext);
        ctl_t c = '0;
        c.st = 3'd2; c.ext_sel = ext;
        return c;
    endfunction

    function automatic ctl_t c_exec(input logic [1:0] ext, input logic [1:0] srcb, input logic [2:0] aop,
                                    input logic [1:0] psrc, input logic pwe);
        ctl_t c = '0;
        c.st = 3'd3; c.ext_sel = ext; c.alu_src_b = srcb; c.alu_op = aop; c.pc_src = psrc; c.pc_we = pwe;
        return c;
    endfunction

    function automatic ctl_t c_mem(input logic [1:0] ext, input logic we);
        ctl_t c = '0;
        c.st = 3'd4; c.ext_sel = ext; c.mem_req = 1'b1; c.i_or_d = 1'b1; c.mem_we = we;
        return c;
    endfunction

    function automatic ctl_t c_wb(input logic [1:0] ext, input logic m2r, input logic dst);
        ctl_t c = '0;
        c.st = 3'd5; c.ext_sel = ext; c.reg_we = 1'b1; c.mem_to_reg = m2r; c.reg_dst = dst;
        return c;
    endfunction

    task automatic add(input stim_t st, input ctl_t e);
        stim_q.push_back(st);
        sb.push_back(e);
    endtask

    task automatic drive(input stim_t st);
        @(negedge clk);
        reset     = st.rst;
        mem_ready = st.rdy;
        alu_zero  = st.zero;
        instr_op  = st.op;
        #1;
    endtask

    task automatic test_reset();
        ctl_t got, e;
        int   n = 0;
        add(s(1, 1, 0, OP_LW),  c_rst());
        add(s(1, 1, 1, OP_BEQ), c_rst());
        add(s(0, 1, 0, OP_LW),  c_rst());
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL reset[%0d]: got %h expected %h", n, got, e); end
            n++;
        end
    endtask

    task automatic test_lw();
        ctl_t got, e;
        int   n = 0;
        add(s(0, 1, 0, OP_LW), c_fetch(1, 2'b00));
        add(s(0, 1, 0, OP_LW), c_decode(2'b00));
        add(s(0, 1, 0, OP_LW), c_exec(2'b00, 2'b10, 3'b000, 2'b00, 0));
        add(s(0, 1, 0, OP_LW), c_mem(2'b00, 0));
        add(s(0, 1, 0, OP_LW), c_wb(2'b00, 1, 0));
        add(s(0, 1, 0, OP_LW), c_fetch(1, 2'b00));
        add(s(0, 1, 0, OP_LW), c_decode(2'b00));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL lw[%0d]: got %h expected %h", n, got, e); end
            n++;
        end
        // Finish the second lw so the next test starts in FETCH.
        repeat (3) drive(s(0, 1, 0, OP_LW));
    endtask

    task automatic test_imm_ext();
        ctl_t got, e;
        int   n = 0;
        add(s(0, 1, 0, OP_ORI), c_fetch(1, 2'b00));
        add(s(0, 1, 0, OP_ORI), c_decode(2'b01));
        add(s(0, 1, 0, OP_ORI), c_exec(2'b01, 2'b10, 3'b011, 2'b00, 0));
        add(s(0, 1, 0, OP_ORI), c_wb(2'b01, 0, 0));
        add(s(0, 1, 0, OP_LUI), c_fetch(1, 2'b01));
        add(s(0, 1, 0, OP_LUI), c_decode(2'b10));
        add(s(0, 1, 0, OP_LUI), c_exec(2'b10, 2'b10, 3'b000, 2'b00, 0));
        add(s(0, 1, 0, OP_LUI), c_wb(2'b10, 0, 0));
        add(s(0, 1, 0, OP_SLT), c_fetch(1, 2'b10));
        add(s(0, 1, 0, OP_SLT), c_decode(2'b00));
        add(s(0, 1, 0, OP_SLT), c_exec(2'b00, 2'b10, 3'b100, 2'b00, 0));
        add(s(0, 1, 0, OP_SLT), c_wb(2'b00, 0, 0));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL imm_ext[%0d]: got %h expected %h", n, got, e); end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        ctl_t got, e;
        int   n = 0;
        add(s(0, 1, 0, OP_R),  c_fetch(1, 2'b00));
        add(s(0, 1, 0, OP_R),  c_decode(2'b00));
        add(s(0, 1, 0, OP_R),  c_exec(2'b00, 2'b00, 3'b111, 2'b00, 0));
        add(s(0, 1, 0, OP_R),  c_wb(2'b00, 0, 1));
        add(s(0, 1, 0, OP_SW), c_fetch(1, 2'b00));
        add(s(0, 1, 0, OP_SW), c_decode(2'b00));
        add(s(0, 1, 0, OP_SW), c_exec(2'b00, 2'b10, 3'b000, 2'b00, 0));
        add(s(0, 1, 0, OP_SW), c_mem(2'b00, 1));
        add(s(0, 1, 0, OP_J),  c_fetch(1, 2'b00));
        add(s(0, 1, 0, OP_J),  c_decode(2'b00));
        add(s(0, 1, 0, OP_J),  c_exec(2'b00, 2'b00, 3'b000, 2'b10, 1));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL back_to_back[%0d]: got %h expected %h", n, got, e); end
            n++;
        end
    endtask

    task automatic test_branch();
        ctl_t got, e;
        int   n = 0;
        logic [5:0] ops  [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        logic       zs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       takes[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            add(s(0, 1, zs[i], ops[i]), c_fetch(1, 2'b00));
            add(s(0, 1, zs[i], ops[i]), c_decode(2'b00));
            add(s(0, 1, zs[i], ops[i]), c_exec(2'b00, 2'b00, 3'b001, 2'b01, takes[i]));
        end
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL branch[%0d]: got %h expected %h", n, got, e); end
            n++;
        end
    endtask

    task automatic test_fetch_wait();
        ctl_t got, e;
        int   n = 0;
        // Three unready cycles, then ready.
        repeat (3) add(s(0, 0, 0, OP_J), c_fetch(0, 2'b00));
        add(s(0, 1, 0, OP_J), c_fetch(1, 2'b00));
        add(s(0, 1, 0, OP_J), c_decode(2'b00));
        add(s(0, 1, 0, OP_J), c_exec(2'b00, 2'b00, 3'b000, 2'b10, 1));
        // Ready arriving on the very cycle the counter hits the limit is not a timeout.
        repeat (4) add(s(0, 0, 0, OP_J), c_fetch(0, 2'b00));
        add(s(0, 1, 0, OP_J), c_fetch(1, 2'b00));
        add(s(0, 1, 0, OP_J), c_decode(2'b00));
        add(s(0, 1, 0, OP_J), c_exec(2'b00, 2'b00, 3'b000, 2'b10, 1));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL fetch_wait[%0d]: got %h expected %h", n, got, e); end
            n++;
        end
    endtask

    task automatic test_mem_timeout();
        ctl_t got, e;
        int   n = 0;
        add(s(0, 1, 0, OP_LW), c_fetch(1, 2'b00));
        add(s(0, 1, 0, OP_LW), c_decode(2'b00));
        add(s(0, 1, 0, OP_LW), c_exec(2'b00, 2'b10, 3'b000, 2'b00, 0));
        repeat (5) add(s(0, 0, 0, OP_LW), c_mem(2'b00, 0));
        add(s(0, 1, 0, OP_LW), c_halt(0, 1));
        add(s(0, 1, 1, OP_J),  c_halt(0, 1));
        add(s(0, 0, 0, OP_R),  c_halt(0, 1));
        add(s(1, 1, 0, OP_LW), c_rst());
        add(s(0, 1, 0, OP_LW), c_rst());
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL mem_timeout[%0d]: got %h expected %h", n, got, e); end
            n++;
        end
    endtask

    task automatic test_illegal();
        ctl_t got, e;
        int   n = 0;
        add(s(0, 1, 0, OP_BAD), c_fetch(1, 2'b00));
        add(s(0, 1, 0, OP_BAD), c_decode(2'b00));
        add(s(0, 1, 0, OP_BAD), c_halt(1, 0));
        add(s(0, 1, 0, OP_LW),  c_halt(1, 0));
        add(s(0, 1, 1, OP_R),   c_halt(1, 0));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL illegal[%0d]: got %h expected %h", n, got, e); end
            n++;
        end
    endtask

    task automatic test_reset_mid_exec();
        ctl_t got, e;
        int   n = 0;
        add(s(1, 1, 0, OP_SW), c_rst());
        add(s(0, 1, 0, OP_SW), c_rst());
        add(s(0, 1, 0, OP_SW), c_fetch(1, 2'b00));
        add(s(0, 1, 0, OP_SW), c_decode(2'b00));
        add(s(0, 1, 0, OP_SW), c_exec(2'b00, 2'b10, 3'b000, 2'b00, 0));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL reset_mid[%0d]: got %h expected %h", n, got, e); end
            n++;
        end
        // Assert reset in the middle of the EXEC cycle, well before the next rising edge.
        #2;
        sb.push_back(c_rst());
        reset = 1'b1;
        #1;
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_async: got %h expected %h", got, e); end
        sb.push_back(c_rst());
        @(posedge clk);
        #1;
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_hold: got %h expected %h", got, e); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_imm_ext();
        test_back_to_back();
        test_branch();
        test_fetch_wait();
        test_mem_timeout();
        test_illegal();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
